// File: rtl/loop_ctrl_stack_pkg.sv
// Shared definitions for the hardware loop controller: default widths, the
// loop opcode encodings shared with ID, and strobe-priority decode.
package loop_ctrl_stack_pkg;

    localparam int PC_WIDTH_DEF  = 16;
    localparam int CNT_WIDTH_DEF = 16;
    localparam int DEPTH_DEF     = 4;

    typedef enum logic [1:0] {
        OP_NONE      = 2'd0,
        OP_LOOPCOUNT = 2'd1,
        OP_STARTLOOP = 2'd2,
        OP_ENDLOOP   = 2'd3
    } loop_op_e;

    // ID should deliver one-hot strobes; if it does not, ENDLOOP wins, then STARTLOOP.
    function automatic loop_op_e decode_op(input logic is_loop_count,
                                           input logic is_start_loop,
                                           input logic is_end_loop);
        loop_op_e op;
        op = OP_NONE;
        if (is_end_loop) begin
            op = OP_ENDLOOP;
        end else if (is_start_loop) begin
            op = OP_STARTLOOP;
        end else if (is_loop_count) begin
            op = OP_LOOPCOUNT;
        end
        return op;
    endfunction

endpackage

// File: rtl/loop_ctrl_stack_if.sv
// Decode-side interface of the loop controller: ID strobes in, fetch redirect
// and loop status out. The slave modport is the controller itself.
interface loop_ctrl_stack_if
    import loop_ctrl_stack_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
);
    localparam int LW = $clog2(DEPTH + 1);

    // An instruction is consumed in exactly the cycle InstValid=1 and Stall=0;
    // while stalled the same strobes are simply re-presented and ignored.
    logic                 Stall;
    logic                 InstValid;
    logic                 IsLoopCount;
    logic                 IsStartLoop;
    logic                 IsEndLoop;
    logic [CNT_WIDTH-1:0] Immediate;
    logic [PC_WIDTH-1:0]  PC;

    logic                 Redirect;
    logic [PC_WIDTH-1:0]  PC_Out;
    logic [LW-1:0]        Level;
    logic [CNT_WIDTH-1:0] CurCount;
    logic                 Overflow;
    logic                 Underflow;
    loop_op_e             DbgOp;

    modport master (
        output Stall, InstValid, IsLoopCount, IsStartLoop, IsEndLoop, Immediate, PC,
        input  Redirect, PC_Out, Level, CurCount, Overflow, Underflow, DbgOp
    );

    modport slave (
        input  Stall, InstValid, IsLoopCount, IsStartLoop, IsEndLoop, Immediate, PC,
        output Redirect, PC_Out, Level, CurCount, Overflow, Underflow, DbgOp
    );

endinterface

// File: rtl/loop_ctrl_stack_stack.sv
// LIFO of {start PC, remaining count} entries for nested loops. Push, pop and
// in-place rewrite of the top entry; at most one of them per cycle.
module loop_ctrl_stack_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          write_top_i,
    input  logic [W-1:0]  push_data_i,
    input  logic [W-1:0]  top_data_i,
    output logic [W-1:0]  top_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [LW-1:0] level_q;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] top_idx;

    always_comb begin
        full_o   = (level_q == LW'(DEPTH));
        empty_o  = (level_q == '0);
        push_idx = IW'(level_q);
        // Guarded by empty_o so the index never goes out of range at level 0.
        top_idx  = empty_o ? '0 : IW'(level_q - LW'(1));
        top_o    = empty_o ? '0 : mem_q[top_idx];
        level_o  = level_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            mem_q[push_idx] <= push_data_i;
            level_q         <= level_q + LW'(1);
        end else if (pop_i && !empty_o) begin
            level_q <= level_q - LW'(1);
        end else if (write_top_i && !empty_o) begin
            mem_q[top_idx] <= top_data_i;
        end
    end

endmodule

// File: rtl/loop_ctrl_stack.sv
// Hardware loop controller beside ID: LOOPCOUNT/STARTLOOP/ENDLOOP handling with
// a nesting stack and zero-latency fetch redirect on ENDLOOP.
module loop_ctrl_stack
    import loop_ctrl_stack_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    loop_ctrl_stack_if.slave lc
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int W  = PC_WIDTH + CNT_WIDTH;

    logic                 accept;
    loop_op_e             op;

    logic [W-1:0]         top_data;
    logic [W-1:0]         push_data;
    logic [W-1:0]         wtop_data;
    logic [PC_WIDTH-1:0]  top_pc;
    logic [CNT_WIDTH-1:0] top_cnt;
    logic [LW-1:0]        level;
    logic                 full;
    logic                 empty;
    logic                 more_iters;

    logic                 push;
    logic                 pop;
    logic                 write_top;
    logic                 redirect;

    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    loop_ctrl_stack_stack #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_loop_stack (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .push_i      (push),
        .pop_i       (pop),
        .write_top_i (write_top),
        .push_data_i (push_data),
        .top_data_i  (wtop_data),
        .top_o       (top_data),
        .level_o     (level),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        accept     = lc.InstValid & ~lc.Stall & ~RESET;
        op         = accept ? decode_op(lc.IsLoopCount, lc.IsStartLoop, lc.IsEndLoop) : OP_NONE;
        top_pc     = top_data[W-1:CNT_WIDTH];
        top_cnt    = top_data[CNT_WIDTH-1:0];
        more_iters = top_cnt > CNT_WIDTH'(1);
        push_data  = {lc.PC + PC_WIDTH'(1), pending_q};
        wtop_data  = {top_pc, top_cnt - CNT_WIDTH'(1)};

        push      = 1'b0;
        pop       = 1'b0;
        write_top = 1'b0;
        redirect  = 1'b0;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        case (op)
            OP_LOOPCOUNT: begin
                // A zero count still runs the body once.
                pending_d = (lc.Immediate == '0) ? CNT_WIDTH'(1) : lc.Immediate;
            end
            OP_STARTLOOP: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    push      = 1'b1;
                    pending_d = CNT_WIDTH'(1);
                end
            end
            OP_ENDLOOP: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else if (more_iters) begin
                    redirect  = 1'b1;
                    write_top = 1'b1;
                end else begin
                    pop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q <= CNT_WIDTH'(1);
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign lc.Redirect  = redirect;
    assign lc.PC_Out    = redirect ? top_pc : '0;
    assign lc.Level     = level;
    assign lc.CurCount  = empty ? '0 : top_cnt;
    assign lc.Overflow  = ovf_q;
    assign lc.Underflow = unf_q;
    assign lc.DbgOp     = op;

endmodule
